// File: rtl/mem_sram_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: FSM encoding, default
// SRAM window base and the CPU-byte to SRAM-word address helper.
package mem_sram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } sram_state_e;

    localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;
    localparam int          SRAM_DW       = 16;

    // 32-bit word index inside the SRAM window; caller truncates to its address width
    function automatic logic [31:0] cpu_word_index(input logic [31:0] cpu_addr,
                                                   input logic [31:0] base_addr);
        return (cpu_addr - base_addr) >> 2;
    endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// Phase wait counter: counts 0..WAIT_CYCLES-1 while enabled, wraps on the
// last count, and flags that last count so the FSM can change phase.
module sram_wait_cnt #(
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o
);

    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE_VAL  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign last_o = (cnt_q == LAST_VAL);

    // next count: clear wins, otherwise advance and wrap on the last count
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (last_o) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + ONE_VAL;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_sram_ctrl.sv
// MEM-stage SRAM controller: splits one 32-bit load/store into a low and a high
// 16-bit access on an asynchronous SRAM, freezing the pipeline until done.
module mem_sram_ctrl
    import mem_sram_ctrl_pkg::*;
#(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
    parameter int          SRAM_AW     = 18
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_en,
    input  logic                wr_en,
    input  logic [31:0]         addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic                ready,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic [SRAM_DW-1:0]  sram_dq_o,
    output logic                sram_dq_oe,
    input  logic [SRAM_DW-1:0]  sram_dq_i,
    output logic                sram_we_n,
    output logic                sram_oe_n,
    output logic                sram_ce_n,
    output logic                sram_ub_n,
    output logic                sram_lb_n
);

    localparam int HW_AW = SRAM_AW - 1;

    sram_state_e        state_q, state_d;
    logic               op_wr_q, op_wr_d;
    logic [HW_AW-1:0]   base_q, base_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
    logic [SRAM_DW-1:0] dq_o_q, dq_o_d;
    logic               dq_oe_q, dq_oe_d;
    logic               we_n_q, we_n_d;
    logic               oe_n_q, oe_n_d;
    logic               ce_n_q, ce_n_d;

    logic               req_s;
    logic               in_phase_s;
    logic               next_phase_s;
    logic               wait_last_s;

    assign req_s        = rd_en | wr_en;
    assign in_phase_s   = (state_q == ST_LO) || (state_q == ST_HI);
    assign next_phase_s = (state_d == ST_LO) || (state_d == ST_HI);

    sram_wait_cnt #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (~in_phase_s),
        .en_i   (in_phase_s),
        .last_o (wait_last_s)
    );

    // FSM next state and request capture; store wins when both requests are set
    always_comb begin
        state_d = state_q;
        op_wr_d = op_wr_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    state_d = ST_LO;
                    op_wr_d = wr_en;
                    base_d  = HW_AW'(cpu_word_index(addr, BASE_ADDR));
                    wdata_d = wdata;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LO: begin
                if (wait_last_s) begin
                    state_d = ST_HI;
                end else begin
                    state_d = ST_LO;
                end
            end
            ST_HI: begin
                if (wait_last_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_HI;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // read data capture on the last cycle of each read phase
    always_comb begin
        rdata_d = rdata_q;
        if (in_phase_s && !op_wr_q && wait_last_s) begin
            if (state_q == ST_LO) begin
                rdata_d[15:0] = sram_dq_i;
            end else begin
                rdata_d[31:16] = sram_dq_i;
            end
        end else begin
            rdata_d = rdata_q;
        end
    end

    // pin values for the coming cycle, decoded from the next state so the
    // registered strobes line up with the phase they belong to
    always_comb begin
        ce_n_d      = ~next_phase_s;
        we_n_d      = ~(next_phase_s & op_wr_d);
        oe_n_d      = ~(next_phase_s & ~op_wr_d);
        dq_oe_d     = next_phase_s & op_wr_d;
        sram_addr_d = sram_addr_q;
        dq_o_d      = dq_o_q;
        case (state_d)
            ST_LO: begin
                sram_addr_d = {base_d, 1'b0};
                dq_o_d      = wdata_d[15:0];
            end
            ST_HI: begin
                sram_addr_d = {base_d, 1'b1};
                dq_o_d      = wdata_d[31:16];
            end
            default: begin
                sram_addr_d = sram_addr_q;
                dq_o_d      = dq_o_q;
            end
        endcase
    end

    // state, latched request and registered SRAM pins
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_wr_q     <= 1'b0;
            base_q      <= '0;
            wdata_q     <= 32'd0;
            rdata_q     <= 32'd0;
            sram_addr_q <= '0;
            dq_o_q      <= '0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            ce_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_wr_q     <= op_wr_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
            dq_o_q      <= dq_o_d;
            dq_oe_q     <= dq_oe_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
            ce_n_q      <= ce_n_d;
        end
    end

    assign ready      = (state_q == ST_DONE) | ((state_q == ST_IDLE) & ~rd_en & ~wr_en);
    assign rdata      = rdata_q;
    assign sram_addr  = sram_addr_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_we_n  = we_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_ub_n  = 1'b0;
    assign sram_lb_n  = 1'b0;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl: a W=2 instance and a W=1 instance, each
// attached to its own 2^18 x 16 SRAM model (combinational read, clocked write).
module tb_mem_sram_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // instance 1: WAIT_CYCLES=2
    logic        rd_en, wr_en;
    logic [31:0] addr, wdata, rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] dq_o, dq_i;
    logic        dq_oe, we_n, oe_n, ce_n, ub_n, lb_n;
    logic [15:0] mem1 [0:262143];

    // instance 2: WAIT_CYCLES=1
    logic        rd_en2, wr_en2;
    logic [31:0] addr2, wdata2, rdata2;
    logic        ready2;
    logic [17:0] sram_addr2;
    logic [15:0] dq_o2, dq_i2;
    logic        dq_oe2, we_n2, oe_n2, ce_n2, ub_n2, lb_n2;
    logic [15:0] mem2 [0:262143];

    mem_sram_ctrl u_dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .sram_addr(sram_addr), .sram_dq_o(dq_o),
        .sram_dq_oe(dq_oe), .sram_dq_i(dq_i), .sram_we_n(we_n), .sram_oe_n(oe_n),
        .sram_ce_n(ce_n), .sram_ub_n(ub_n), .sram_lb_n(lb_n)
    );

    mem_sram_ctrl #(.WAIT_CYCLES(1)) u_dut2 (
        .clk(clk), .rst(rst), .rd_en(rd_en2), .wr_en(wr_en2), .addr(addr2), .wdata(wdata2),
        .rdata(rdata2), .ready(ready2), .sram_addr(sram_addr2), .sram_dq_o(dq_o2),
        .sram_dq_oe(dq_oe2), .sram_dq_i(dq_i2), .sram_we_n(we_n2), .sram_oe_n(oe_n2),
        .sram_ce_n(ce_n2), .sram_ub_n(ub_n2), .sram_lb_n(lb_n2)
    );

    assign dq_i  = mem1[sram_addr];
    assign dq_i2 = mem2[sram_addr2];

    always @(posedge clk) begin
        if (!ce_n && !we_n) mem1[sram_addr] <= dq_o;
    end

    always @(posedge clk) begin
        if (!ce_n2 && !we_n2) mem2[sram_addr2] <= dq_o2;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    int          low_cnt, we_low_cnt;
    logic [31:0] rd_seen;
    logic [17:0] alog [4];

    // one transaction on instance 1; called just after a posedge
    task automatic run_txn(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        int k;
        wr_en = w; rd_en = r; addr = a; wdata = d;
        low_cnt = 0; we_low_cnt = 0; k = 0; rd_seen = 32'd0;
        for (int i = 0; i < 4; i++) alog[i] = 18'd0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!we_n) we_low_cnt++;
            if (!ce_n && k < 4) begin
                alog[k] = sram_addr;
                k++;
            end
            if (ready) begin
                rd_seen = rdata;
                break;
            end
            low_cnt++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi_cnt, waited;
        logic [31:0] last_rdata;
        logic        last_ready;

        rst = 1'b1;
        rd_en = 1'b0; wr_en = 1'b0; addr = 32'd0; wdata = 32'd0;
        rd_en2 = 1'b0; wr_en2 = 1'b0; addr2 = 32'd0; wdata2 = 32'd0;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("rst_pins1", 32'({ready, ce_n, oe_n, we_n, dq_oe, ub_n, lb_n}), 32'b1111000);
        check_val("rst_rdata", rdata, 32'd0);
        check_val("rst_addr",  32'(sram_addr), 32'd0);
        check_val("rst_dq_o",  32'(dq_o), 32'd0);
        check_val("rst_pins2", 32'({ready2, ce_n2, oe_n2, we_n2, dq_oe2, ub_n2, lb_n2}), 32'b1111000);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: idle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("idle_pins", 32'({ready, ce_n, oe_n, we_n, dq_oe}), 32'b11110);
            @(posedge clk); #1;
        end

        // 2: store 0xDEADBEEF at 1028 -> half-words 2, 3
        run_txn(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF);
        check_val("wr_low_cycles", 32'(low_cnt), 32'd5);
        check_val("wr_we_cycles",  32'(we_low_cnt), 32'd4);
        check_val("wr_mem2",       32'(mem1[2]), 32'h0000BEEF);
        check_val("wr_mem3",       32'(mem1[3]), 32'h0000DEAD);
        check_val("wr_rdata_kept", rd_seen, 32'd0);

        // 3: load back from 1028
        run_txn(1'b0, 1'b1, 32'd1028, 32'd0);
        check_val("rd_low_cycles", 32'(low_cnt), 32'd5);
        check_val("rd_data",       rd_seen, 32'hDEADBEEF);
        check_val("rd_addr_lo",    32'(alog[0]), 32'd2);
        check_val("rd_addr_hi",    32'(alog[3]), 32'd3);
        check_val("rd_no_we",      32'(we_low_cnt), 32'd0);

        // 4: both requests -> store wins
        run_txn(1'b1, 1'b1, 32'd1024, 32'h12345678);
        check_val("both_we_cycles", 32'(we_low_cnt), 32'd4);
        check_val("both_mem0",      32'(mem1[0]), 32'h00005678);
        check_val("both_mem1",      32'(mem1[1]), 32'h00001234);
        run_txn(1'b0, 1'b1, 32'd1024, 32'd0);
        check_val("both_readback",  rd_seen, 32'h12345678);

        // 5: reset during the low write phase
        run_txn(1'b1, 1'b0, 32'd1032, 32'hAAAA0000);
        check_val("pre_mem5", 32'(mem1[5]), 32'h0000AAAA);
        wr_en = 1'b1; addr = 32'd1032; wdata = 32'h55556666;
        @(negedge clk);
        check_val("abort_c1_ready", 32'(ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("abort_lo_we", 32'(we_n), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        check_val("abort_pins",  32'({ready, ce_n, we_n, dq_oe}), 32'b1110);
        check_val("abort_rdata", rdata, 32'd0);
        check_val("abort_mem5",  32'(mem1[5]), 32'h0000AAAA);
        @(posedge clk); #1;

        // 6a: load held 12 cycles on W=2 -> two transactions
        rd_en = 1'b1; addr = 32'd1024;
        hi_cnt = 0; last_ready = 1'b0; last_rdata = 32'd0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ready) hi_cnt++;
            last_ready = ready;
            last_rdata = rdata;
            @(posedge clk); #1;
        end
        rd_en = 1'b0;
        check_val("b2b_ready_pulses", 32'(hi_cnt), 32'd2);
        check_val("b2b_last_ready",   32'(last_ready), 32'd1);
        check_val("b2b_rdata",        last_rdata, 32'h12345678);

        // 6b: store held 8 cycles on W=1 -> two transactions
        wr_en2 = 1'b1; addr2 = 32'd1024; wdata2 = 32'hCAFEF00D;
        hi_cnt = 0; last_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ready2) hi_cnt++;
            last_ready = ready2;
            @(posedge clk); #1;
        end
        wr_en2 = 1'b0;
        check_val("w1_ready_pulses", 32'(hi_cnt), 32'd2);
        check_val("w1_last_ready",   32'(last_ready), 32'd1);
        check_val("w1_mem0",         32'(mem2[0]), 32'h0000F00D);
        check_val("w1_mem1",         32'(mem2[1]), 32'h0000CAFE);

        // 6c: load on W=1 with rd_en dropped after the first cycle
        rd_en2 = 1'b1; addr2 = 32'd1024;
        @(negedge clk);
        check_val("drop_c1_ready", 32'(ready2), 32'd0);
        @(posedge clk); #1;
        rd_en2 = 1'b0;
        waited = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ready2) break;
            waited++;
            @(posedge clk); #1;
        end
        check_val("drop_wait", 32'(waited), 32'd2);
        check_val("drop_rdata", rdata2, 32'hCAFEF00D);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
